// File: rtl/sum_i_q_requant_buffer_if.sv
// Stream bundle for the requantiser: the 22-bit beam-sum input (strobe only, no stall)
// and the 16-bit valid/ready output toward the downstream chain.
interface sum_i_q_requant_buffer_if #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  sum_in_I;
  logic [IN_W-1:0]  sum_in_Q;
  logic             sum_in_valid;
  logic [OUT_W-1:0] data_out_I;
  logic [OUT_W-1:0] data_out_Q;
  logic             data_out_valid;
  logic             data_out_ready;

  modport master (
    output sum_in_I, sum_in_Q, sum_in_valid, data_out_ready,
    input  data_out_I, data_out_Q, data_out_valid
  );

  modport slave (
    input  sum_in_I, sum_in_Q, sum_in_valid, data_out_ready,
    output data_out_I, data_out_Q, data_out_valid
  );
endinterface

// File: rtl/sum_i_q_requant_buffer.sv
// Round-half-up, shift and saturate 22-bit I/Q beam sums to 16 bits, then buffer them
// in a show-ahead FIFO with a valid/ready output and sticky saturation/overflow flags.
module sum_i_q_requant_buffer #(
  parameter int IN_W       = 22,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              shift,
  input  logic                    clear_flags,
  sum_i_q_requant_buffer_if.slave bus,
  output logic [CNT_W-1:0]        fifo_count,
  output logic                    sat_flag,
  output logic                    overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

  // One extra bit of headroom so the rounding bias can never wrap the sign.
  function automatic logic signed [IN_W:0] round_shift(input logic [IN_W-1:0] x,
                                                        input logic [2:0]      s);
    logic signed [IN_W:0] xe;
    logic signed [IN_W:0] bias;
    xe   = $signed({x[IN_W-1], x});
    bias = (s == 3'd0) ? '0 : $signed((IN_W+1)'(1) << (s - 3'd1));
    return (xe + bias) >>> s;
  endfunction

  // Stage 1: rounded and shifted sample
  logic                 s1_valid_q;
  logic signed [IN_W:0] s1_i_q, s1_q_q, s1_i_d, s1_q_d;
  logic [2:0]           shift_eff;

  always_comb begin
    shift_eff = (shift == 3'd7) ? 3'd6 : shift;
    s1_i_d    = round_shift(bus.sum_in_I, shift_eff);
    s1_q_d    = round_shift(bus.sum_in_Q, shift_eff);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
    end else begin
      s1_valid_q <= bus.sum_in_valid;
      if (bus.sum_in_valid) begin
        s1_i_q <= s1_i_d;
        s1_q_q <= s1_q_d;
      end
    end
  end

  // Stage 2: saturate and decide push/pop
  logic             i_hi, i_lo, q_hi, q_lo, sample_sat;
  logic [OUT_W-1:0] sat_i, sat_q;
  logic             full, empty, pop, push, drop;

  logic [OUT_W-1:0] mem_i [FIFO_DEPTH];
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] last_i_q, last_q_q, last_i_d, last_q_d;
  logic             sat_q_r, sat_d, ovf_q, ovf_d;

  // NOTE: every variable in this block gets a default first, so no latch can be inferred.
  always_comb begin
    i_hi       = s1_i_q > SAT_MAX;
    i_lo       = s1_i_q < SAT_MIN;
    q_hi       = s1_q_q > SAT_MAX;
    q_lo       = s1_q_q < SAT_MIN;
    sat_i      = i_hi ? SAT_MAX[OUT_W-1:0] : (i_lo ? SAT_MIN[OUT_W-1:0] : s1_i_q[OUT_W-1:0]);
    sat_q      = q_hi ? SAT_MAX[OUT_W-1:0] : (q_lo ? SAT_MIN[OUT_W-1:0] : s1_q_q[OUT_W-1:0]);
    sample_sat = s1_valid_q && (i_hi || i_lo || q_hi || q_lo);

    full  = (count_q == CNT_W'(FIFO_DEPTH));
    empty = (count_q == '0);
    pop   = !empty && bus.data_out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push  = s1_valid_q && (!full || pop);
    drop  = s1_valid_q && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    last_i_d = pop ? mem_i[rd_ptr_q] : last_i_q;
    last_q_d = pop ? mem_q[rd_ptr_q] : last_q_q;

    sat_d = sample_sat || (sat_q_r && !clear_flags);
    ovf_d = drop       || (ovf_q   && !clear_flags);
  end

  // NOTE: the storage array is not reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr_q] <= sat_i;
      mem_q[wr_ptr_q] <= sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_i_q <= '0;
      last_q_q <= '0;
      sat_q_r  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_i_q <= last_i_d;
      last_q_q <= last_q_d;
      sat_q_r  <= sat_d;
      ovf_q    <= ovf_d;
    end
  end

  // When empty the output parks on the last popped value rather than stale array contents.
  assign bus.data_out_I     = empty ? last_i_q : mem_i[rd_ptr_q];
  assign bus.data_out_Q     = empty ? last_q_q : mem_q[rd_ptr_q];
  assign bus.data_out_valid = !empty;
  assign fifo_count         = count_q;
  assign sat_flag           = sat_q_r;
  assign overflow           = ovf_q;

endmodule

// File: tb/tb_sum_i_q_requant_buffer.sv
// Directed bench for sum_i_q_requant_buffer: a queue-based reference model is compared
// every cycle, and hand-computed literals pin the key scenarios.
module tb_sum_i_q_requant_buffer;
  localparam int IN_W  = 22;
  localparam int OUT_W = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] shift;
  logic       clear_flags;
  logic [4:0] fifo_count;
  logic       sat_flag, overflow;

  sum_i_q_requant_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sum_i_q_requant_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .shift       (shift),
    .clear_flags (clear_flags),
    .bus         (bus),
    .fifo_count  (fifo_count),
    .sat_flag    (sat_flag),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: floor((x + half) / 2^s), then clip to the 16-bit range.
  function automatic int requant(input int x, input int sh, output bit sat);
    int     s;
    longint d, v, r;
    s   = (sh > 6) ? 6 : sh;
    d   = longint'(1) << s;
    v   = longint'(x) + ((s > 0) ? d / 2 : 0);
    r   = (v >= 0) ? v / d : -((-v + d - 1) / d);
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767; sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768; sat = 1'b1;
    end
    return int'(r);
  endfunction

  // Model state: a two-edge delay slot in front of a bounded queue.
  int mq_i[$];
  int mq_q[$];
  int last_i, last_q;
  bit st_v, st_sat;
  int st_i, st_q;
  bit m_sat, m_ovf;
  bit checking = 1'b0;

  always @(posedge clk) begin
    bit c_v, c_sat, si, sq, pop, full, ovf_set;
    int c_i, c_q;
    if (rst) begin
      st_v = 1'b0; st_sat = 1'b0; st_i = 0; st_q = 0;
      mq_i.delete(); mq_q.delete();
      last_i = 0; last_q = 0;
      m_sat = 1'b0; m_ovf = 1'b0;
    end else begin
      c_v = st_v; c_i = st_i; c_q = st_q; c_sat = st_sat;
      st_v = bus.sum_in_valid;
      if (st_v) begin
        st_i   = requant(int'($signed(bus.sum_in_I)), int'(shift), si);
        st_q   = requant(int'($signed(bus.sum_in_Q)), int'(shift), sq);
        st_sat = si || sq;
      end
      full    = (mq_i.size() == DEPTH);
      pop     = (mq_i.size() != 0) && bus.data_out_ready;
      ovf_set = 1'b0;
      if (pop) begin
        last_i = mq_i.pop_front();
        last_q = mq_q.pop_front();
      end
      if (c_v) begin
        if (full && !pop) ovf_set = 1'b1;
        else begin
          mq_i.push_back(c_i);
          mq_q.push_back(c_q);
        end
      end
      m_sat = (c_v && c_sat) || (m_sat && !clear_flags);
      m_ovf = ovf_set || (m_ovf && !clear_flags);
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (checking) begin
      ev = (mq_i.size() != 0);
      check("m_valid", int'(bus.data_out_valid), int'(ev));
      check("m_count", int'(fifo_count), mq_i.size());
      check("m_out_I", int'($signed(bus.data_out_I)), ev ? mq_i[0] : last_i);
      check("m_out_Q", int'($signed(bus.data_out_Q)), ev ? mq_q[0] : last_q);
      check("m_sat",   int'(sat_flag), int'(m_sat));
      check("m_ovf",   int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int i, input int q, input int sh);
    bus.sum_in_valid = 1'b1;
    bus.sum_in_I     = IN_W'(i);
    bus.sum_in_Q     = IN_W'(q);
    shift            = 3'(sh);
    tick();
    bus.sum_in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  function automatic int s16(input logic [OUT_W-1:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    rst = 1'b1; clear_flags = 1'b0; shift = '0;
    bus.sum_in_valid = 1'b0; bus.sum_in_I = '0; bus.sum_in_Q = '0;
    bus.data_out_ready = 1'b0;
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", int'(bus.data_out_valid), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_I", s16(bus.data_out_I), 0);
    check("rst_flags", int'({sat_flag, overflow}), 0);

    // Pass-through at shift 0 and two-cycle latency
    send(1000, -1000, 0);
    check("t1_latency", int'(bus.data_out_valid), 0);
    tick();
    check("t1_valid", int'(bus.data_out_valid), 1);
    check("t1_I", s16(bus.data_out_I), 1000);
    check("t1_Q", s16(bus.data_out_Q), -1000);
    check("t1_count", int'(fifo_count), 1);
    bus.data_out_ready = 1'b1;
    tick();
    check("t1_empty", int'(bus.data_out_valid), 0);
    check("t1_hold", s16(bus.data_out_I), 1000);
    bus.data_out_ready = 1'b0;

    // Rounding and shift clamp
    send(12, -12, 3);
    send(20, 0, 3);
    send(64, 0, 7);
    idle(2);
    check("t2_count", int'(fifo_count), 3);
    check("t2_I0", s16(bus.data_out_I), 2);
    check("t2_Q0", s16(bus.data_out_Q), -1);
    bus.data_out_ready = 1'b1;
    tick();
    check("t2_I1", s16(bus.data_out_I), 3);
    tick();
    check("t2_I2_clamp", s16(bus.data_out_I), 1);
    tick();
    bus.data_out_ready = 1'b0;
    check("t2_drained", int'(bus.data_out_valid), 0);

    // Saturation and sticky flag
    send(40000, -40000, 0);
    idle(2);
    check("t3_I", s16(bus.data_out_I), 32767);
    check("t3_Q", s16(bus.data_out_Q), -32768);
    check("t3_sat", int'(sat_flag), 1);
    pulse_clear();
    check("t3_clear", int'(sat_flag), 0);
    bus.data_out_ready = 1'b1;
    send(32767, -32768, 0);
    send(65534, -65536, 1);
    send(-2097152, 0, 6);
    idle(3);
    check("t3_edge_nosat", int'(sat_flag), 0);
    send(32768, 0, 0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("t3_set_wins", int'(sat_flag), 1);
    pulse_clear();
    check("t3_clear2", int'(sat_flag), 0);
    idle(2);
    bus.data_out_ready = 1'b0;

    // Fill past capacity, then drain in order
    for (int i = 1; i <= 17; i++) send(i, -i, 0);
    idle(2);
    check("t4_count", int'(fifo_count), 16);
    check("t4_ovf", int'(overflow), 1);
    bus.data_out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("t4_order_I", s16(bus.data_out_I), k);
      check("t4_order_Q", s16(bus.data_out_Q), -k);
      tick();
    end
    check("t4_empty", int'(bus.data_out_valid), 0);
    bus.data_out_ready = 1'b0;
    pulse_clear();
    check("t4_ovf_clear", int'(overflow), 0);

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 16; i++) send(100 + i, -(100 + i), 0);
    idle(2);
    check("t5_full", int'(fifo_count), 16);
    send(200, -200, 0);
    bus.data_out_ready = 1'b1;
    for (int j = 1; j <= 7; j++) send(200 + j, -(200 + j), 0);
    check("t5_count", int'(fifo_count), 16);
    check("t5_no_ovf", int'(overflow), 0);
    idle(20);
    check("t5_drained", int'(fifo_count), 0);
    bus.data_out_ready = 1'b0;

    // Reset with queued entries and samples in flight
    send(1, 1, 0);
    send(50000, 2, 0);
    send(3, 3, 0);
    send(4, 4, 0);
    send(5, 5, 0);
    idle(2);
    check("t6_count", int'(fifo_count), 5);
    check("t6_sat", int'(sat_flag), 1);
    send(300, 300, 0);
    rst = 1'b1;
    bus.sum_in_valid = 1'b1; bus.sum_in_I = IN_W'(301); bus.sum_in_Q = IN_W'(301);
    tick();
    rst = 1'b0;
    bus.sum_in_valid = 1'b0;
    check("t6_count0", int'(fifo_count), 0);
    check("t6_valid0", int'(bus.data_out_valid), 0);
    check("t6_I0", s16(bus.data_out_I), 0);
    check("t6_Q0", s16(bus.data_out_Q), 0);
    check("t6_flags0", int'({sat_flag, overflow}), 0);
    bus.data_out_ready = 1'b1;
    idle(5);
    check("t6_no_stale", int'(bus.data_out_valid), 0);
    check("t6_no_stale_cnt", int'(fifo_count), 0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
